// File: rtl/exh_stim_pkg.sv
// Shared types and helpers for the exhaustive-stimulus capture block:
// FSM state encoding, pattern-count computation and parameter range checks.
package exh_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Number of exhaustive patterns for an n-input circuit.
  function automatic int npat_f(input int n_in);
    return 1 << n_in;
  endfunction

  // Circuit width is limited so the response vector stays a practical size.
  function automatic bit n_in_legal(input int n_in);
    return (n_in >= 1) && (n_in <= 10);
  endfunction

  // At least one settle cycle is needed before the output is sampled.
  function automatic bit settle_legal(input int settle);
    return settle >= 1;
  endfunction

endpackage

// File: rtl/exh_pat_counter.sv
// Pattern register for the exhaustive sweep: synchronous clear, increment
// enable that never wraps past the all-ones terminal pattern, terminal flag.
module exh_pat_counter #(
  parameter int N_IN = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [N_IN-1:0] pat,
  output logic            last
);

  logic [N_IN-1:0] pat_q, pat_d;

  // Next pattern: clear has priority, increment stops at the terminal pattern.
  always_comb begin
    pat_d = pat_q;
    if (clr) begin
      pat_d = '0;
    end else if (inc && !last) begin
      pat_d = pat_q + 1'b1;
    end
  end

  // Pattern register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= '0;
    end else begin
      pat_q <= pat_d;
    end
  end

  assign pat  = pat_q;
  assign last = &pat_q;

endmodule

// File: rtl/exh_pattern_capture.sv
// Exhaustive-stimulus sequencer and response capture. Walks every input
// pattern in ascending order, holds each for SETTLE cycles, samples the
// circuit output, streams the (pattern, response) pair over valid/ready and
// accumulates the full response vector and ones-count.
// Optional golden comparison is built when GOLDEN_CMP_EN is defined.
module exh_pattern_capture
  import exh_stim_pkg::*;
#(
  parameter int  N_IN   = 5,
  parameter int  SETTLE = 1,
  localparam int NPAT   = npat_f(N_IN)
) (
  input  logic            CK,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] pat_out,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [N_IN-1:0] resp_pat,
  output logic            resp_bit,
  output logic [NPAT-1:0] resp_vec,
`ifdef GOLDEN_CMP_EN
  input  logic [NPAT-1:0] golden,
  output logic            mismatch,
  output logic [N_IN-1:0] first_mm_idx,
`endif
  output logic [N_IN:0]   ones_cnt
);

  if (!n_in_legal(N_IN)) begin : g_bad_n_in
    $error("exh_pattern_capture: N_IN must be in 1..10");
  end
  if (!settle_legal(SETTLE)) begin : g_bad_settle
    $error("exh_pattern_capture: SETTLE must be >= 1");
  end

  localparam int            CW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] resp_pat_q, resp_pat_d;
  logic            resp_bit_q, resp_bit_d;
  logic [NPAT-1:0] resp_vec_q, resp_vec_d;
  logic [N_IN:0]   ones_cnt_q, ones_cnt_d;
  logic            pat_clr, pat_inc, pat_last;
  logic [N_IN-1:0] pat;
`ifdef GOLDEN_CMP_EN
  logic            mismatch_q, mismatch_d;
  logic [N_IN-1:0] first_mm_q, first_mm_d;
`endif

  exh_pat_counter #(.N_IN(N_IN)) u_pat_counter (
    .clk  (CK),
    .rst  (reset),
    .clr  (pat_clr),
    .inc  (pat_inc),
    .pat  (pat),
    .last (pat_last)
  );

  // Sweep FSM next-state and capture datapath.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    resp_pat_d = resp_pat_q;
    resp_bit_d = resp_bit_q;
    resp_vec_d = resp_vec_q;
    ones_cnt_d = ones_cnt_q;
    pat_clr    = 1'b0;
    pat_inc    = 1'b0;
`ifdef GOLDEN_CMP_EN
    mismatch_d = mismatch_q;
    first_mm_d = first_mm_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pat_clr    = 1'b1;
          resp_vec_d = '0;
          ones_cnt_d = '0;
          cnt_d      = CNT_RELOAD;
          state_d    = ST_SETTLE;
`ifdef GOLDEN_CMP_EN
          mismatch_d = 1'b0;
          first_mm_d = '0;
`endif
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SAMPLE: begin
        resp_bit_d      = dut_out;
        resp_pat_d      = pat;
        resp_vec_d[pat] = dut_out;
        // Cannot overflow: at most NPAT ones, which fits in N_IN+1 bits.
        ones_cnt_d      = ones_cnt_q + (N_IN + 1)'(dut_out);
`ifdef GOLDEN_CMP_EN
        if (dut_out != golden[pat]) begin
          mismatch_d = 1'b1;
          if (!mismatch_q) begin
            first_mm_d = pat;
          end
        end
`endif
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        // Pair is held until the writer accepts it; no resampling meanwhile.
        if (resp_ready) begin
          if (pat_last) begin
            state_d = ST_DONE;
          end else begin
            pat_inc = 1'b1;
            cnt_d   = CNT_RELOAD;
            state_d = ST_SETTLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and capture registers; reset discards any partial sweep.
  always_ff @(posedge CK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      resp_pat_q <= '0;
      resp_bit_q <= 1'b0;
      resp_vec_q <= '0;
      ones_cnt_q <= '0;
`ifdef GOLDEN_CMP_EN
      mismatch_q <= 1'b0;
      first_mm_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      resp_pat_q <= resp_pat_d;
      resp_bit_q <= resp_bit_d;
      resp_vec_q <= resp_vec_d;
      ones_cnt_q <= ones_cnt_d;
`ifdef GOLDEN_CMP_EN
      mismatch_q <= mismatch_d;
      first_mm_q <= first_mm_d;
`endif
    end
  end

  assign pat_out    = pat;
  assign busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE) || (state_q == ST_EMIT);
  assign done       = (state_q == ST_DONE);
  assign resp_valid = (state_q == ST_EMIT);
  assign resp_pat   = resp_pat_q;
  assign resp_bit   = resp_bit_q;
  assign resp_vec   = resp_vec_q;
  assign ones_cnt   = ones_cnt_q;
`ifdef GOLDEN_CMP_EN
  assign mismatch     = mismatch_q;
  assign first_mm_idx = first_mm_q;
`endif

endmodule

// File: tb/tb_exh_pattern_capture.sv
// Bench for exh_pattern_capture (N_IN=5, SETTLE=1): table of sweeps over
// modelled circuits plus hand sequences for reset, start and stall cases.
module tb_exh_pattern_capture;

  localparam int N_IN   = 5;
  localparam int SETTLE = 1;
  localparam int NPAT   = 32;

  logic            CK = 1'b0;
  logic            reset;
  logic            start;
  logic [N_IN-1:0] pat_out;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            resp_valid;
  logic            resp_ready;
  logic [N_IN-1:0] resp_pat;
  logic            resp_bit;
  logic [NPAT-1:0] resp_vec;
  logic [N_IN:0]   ones_cnt;
`ifdef GOLDEN_CMP_EN
  logic [NPAT-1:0] golden = 32'h8000_0000;
  logic            mismatch;
  logic [N_IN-1:0] first_mm_idx;
`endif

  int mode     = 0;
  int rdy_mode = 0;
  int cyc      = 0;
  int errors   = 0;
  int checks   = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [N_IN-1:0] pat;
    logic            b;
  } pair_t;
  pair_t sb[$];

  typedef struct {
    int        m;
    int        rdy;
    logic [31:0] exp_vec;
    int        exp_ones;
    bit        timed;
    int        poke;
  } vec_t;

  always #5 CK = ~CK;

  // Circuit under test: 0 = AND, 1 = XOR, otherwise OR of all inputs.
  function automatic logic circuit(input int m, input logic [N_IN-1:0] p);
    case (m)
      0:       return &p;
      1:       return ^p;
      default: return |p;
    endcase
  endfunction

  assign dut_out = circuit(mode, pat_out);

  exh_pattern_capture #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .CK           (CK),
    .reset        (reset),
    .start        (start),
    .pat_out      (pat_out),
    .dut_out      (dut_out),
    .busy         (busy),
    .done         (done),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_pat     (resp_pat),
    .resp_bit     (resp_bit),
    .resp_vec     (resp_vec),
`ifdef GOLDEN_CMP_EN
    .golden       (golden),
    .mismatch     (mismatch),
    .first_mm_idx (first_mm_idx),
`endif
    .ones_cnt     (ones_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready driver: 0 = always high, 1 = high one cycle in three, else low.
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge CK);
      #1;
      cyc++;
      case (rdy_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = (cyc % 3 == 0);
        default: resp_ready = 1'b0;
      endcase
    end
  end

  // Stream monitor: pops the scoreboard on each handshake and checks that a
  // stalled pair and the driven pattern stay put until accepted.
  initial begin
    bit              held_v;
    logic [N_IN-1:0] held_pat, held_rpat;
    logic            held_bit;
    pair_t           e;
    held_v = 1'b0;
    forever begin
      @(negedge CK);
      if (check_en) begin
        if (held_v && resp_valid) begin
          chk("stall_pat_out", pat_out, held_pat);
          chk("stall_resp_pat", resp_pat, held_rpat);
          chk("stall_resp_bit", resp_bit, held_bit);
        end
        held_v = 1'b0;
        if (resp_valid && resp_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra_pair: got pattern %0h with no pair expected", resp_pat);
          end else begin
            e = sb.pop_front();
            chk("pair_pat", resp_pat, e.pat);
            chk("pair_bit", resp_bit, e.b);
          end
        end else if (resp_valid) begin
          held_v    = 1'b1;
          held_pat  = pat_out;
          held_rpat = resp_pat;
          held_bit  = resp_bit;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic load_sb(input int m);
    sb.delete();
    for (int i = 0; i < NPAT; i++) begin
      pair_t p;
      p.pat = N_IN'(i);
      p.b   = circuit(m, N_IN'(i));
      sb.push_back(p);
    end
  endtask

  // Full sweep: start, optionally poke start while busy, check final state.
  task automatic run_sweep(input vec_t v);
    int n;
    bit poked;
    mode     = v.m;
    rdy_mode = v.rdy;
    load_sb(v.m);
    check_en = 1'b1;
    @(posedge CK); #1;
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_pat0", pat_out, 0);
    chk("start_vec_clr", resp_vec, 0);
    chk("start_ones_clr", ones_cnt, 0);
    n = 0;
    poked = 1'b0;
    while (!done && n < 3000) begin
      @(posedge CK); #1;
      n++;
      start = 1'b0;
      if (n == 1) chk("first_valid_low", resp_valid, 0);
      if (n == 2) chk("first_valid_high", resp_valid, 1);
      if (v.poke >= 0 && !poked && busy && pat_out == N_IN'(v.poke)) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    start = 1'b0;
    chk("sweep_done", done, 1);
    if (v.timed) chk("sweep_cycles", n, NPAT * (SETTLE + 2));
    chk("final_vec", resp_vec, v.exp_vec);
    chk("final_ones", ones_cnt, v.exp_ones);
    chk("final_pat_out", pat_out, NPAT - 1);
    chk("final_busy", busy, 0);
    chk("final_valid", resp_valid, 0);
    chk("sb_pairs_left", sb.size(), 0);
    check_en = 1'b0;
  endtask

  initial begin
    vec_t tbl[4];
    int   n;
    tbl[0] = '{m: 0, rdy: 0, exp_vec: 32'h8000_0000, exp_ones: 1,  timed: 1'b1, poke: -1};
    tbl[1] = '{m: 1, rdy: 0, exp_vec: 32'h9669_6996, exp_ones: 16, timed: 1'b1, poke: -1};
    tbl[2] = '{m: 1, rdy: 1, exp_vec: 32'h9669_6996, exp_ones: 16, timed: 1'b0, poke: -1};
    tbl[3] = '{m: 2, rdy: 0, exp_vec: 32'hFFFF_FFFE, exp_ones: 31, timed: 1'b1, poke: 3};

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_pat_out", pat_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_resp_pat", resp_pat, 0);
    chk("rst_resp_bit", resp_bit, 0);
    chk("rst_vec", resp_vec, 0);
    chk("rst_ones", ones_cnt, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
`ifdef GOLDEN_CMP_EN
      golden = 32'h8000_0000;
`endif
      run_sweep(tbl[i]);
`ifdef GOLDEN_CMP_EN
      chk("golden_mismatch", mismatch, (tbl[i].m == 0) ? 0 : 1);
      chk("golden_first_idx", first_mm_idx, (tbl[i].m == 0) ? 0 : 1);
`endif
    end

    // Reset while pattern 7 is being emitted discards the partial sweep.
    mode     = 0;
    rdy_mode = 0;
    load_sb(0);
    check_en = 1'b1;
    @(posedge CK); #1;
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    n = 0;
    while (!(resp_valid && resp_pat == 5'd7) && n < 500) begin
      @(posedge CK); #1;
      n++;
    end
    chk("reach_pat7", resp_valid && resp_pat == 5'd7, 1);
    reset = 1'b1;
    @(posedge CK); #1;
    check_en = 1'b0;
    sb.delete();
    chk("mid_rst_pat_out", pat_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_resp_pat", resp_pat, 0);
    chk("mid_rst_resp_bit", resp_bit, 0);
    chk("mid_rst_vec", resp_vec, 0);
    chk("mid_rst_ones", ones_cnt, 0);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    @(posedge CK); #1;
    chk("rst_beats_start_busy", busy, 0);
    chk("rst_beats_start_pat", pat_out, 0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge CK); #1;
    chk("idle_stays_idle", busy, 0);

`ifdef GOLDEN_CMP_EN
    golden = 32'h8000_0000;
`endif
    run_sweep(tbl[0]);
`ifdef GOLDEN_CMP_EN
    chk("golden_after_rst", mismatch, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    repeat (60000) @(posedge CK);
    $display("FAIL watchdog: bench still running after 60000 cycles, expected to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
